hazard_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage SIMD/AES processor (F, D, E, M, W).
- Consumes the conditional unit's outputs (BranchTakenE, PCSrcM, RegWriteM) plus the later-stage writeback controls.
- Produces forwarding selects for the execute-stage ALU operand muxes, and stall/flush controls for the pipeline registers.
- Adds a sequential stall sequencer that holds F/D/E while a multi-cycle vector (AES round) operation occupies execute.

---
 rtl/hazard_unit.sv | 129 ++++++++++++
 tb/tb_hazard_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage SIMD/AES pipeline: operand forwarding,
// load-use / PC-write stalls and flushes, and a multi-cycle vector stall sequencer.
module hazard_unit #(
    parameter int REG_ADDR_W  = 4,
    parameter int VEC_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] RA1D,
    input  logic [REG_ADDR_W-1:0] RA2D,
    input  logic [REG_ADDR_W-1:0] RA1E,
    input  logic [REG_ADDR_W-1:0] RA2E,
    input  logic [REG_ADDR_W-1:0] WA3E,
    input  logic [REG_ADDR_W-1:0] WA3M,
    input  logic [REG_ADDR_W-1:0] WA3W,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemtoRegE,
    input  logic                  PCSrcD,
    input  logic                  PCSrcE,
    input  logic                  PCSrcM,
    input  logic                  PCSrcW,
    input  logic                  BranchTakenE,
    input  logic                  VecOpE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  VecBusy,
    output logic                  VecDoneE
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    localparam bit         MULTI    = (VEC_LATENCY > 1);
    localparam logic [3:0] CNT_LOAD = MULTI ? 4'(VEC_LATENCY - 2) : 4'd0;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    logic w_ldr_stall;
    logic w_pc_pending;
    logic w_vec_start;
    logic w_vec_stall;
    logic w_vec_done;

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (WA3M == RA1E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (WA3W == RA1E))
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (WA3M == RA2E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (WA3W == RA2E))
            ForwardBE = 2'b01;
    end

    assign w_ldr_stall  = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    assign w_pc_pending = PCSrcD | PCSrcE | PCSrcM;

    // A taken branch wins over a coincident vector op: the op is squashed.
    assign w_vec_start = VecOpE & ~BranchTakenE;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_vec_stall = 1'b0;
        w_vec_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (MULTI) begin
                    if (w_vec_start) begin
                        w_vec_stall = 1'b1;
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = S_BUSY;
                    end
                end else begin
                    w_vec_done = w_vec_start;
                end
            end
            S_BUSY: begin
                if (r_cnt != 4'd0) begin
                    w_vec_stall = 1'b1;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end else begin
                    w_vec_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign StallF   = w_ldr_stall | w_pc_pending | w_vec_stall;
    assign StallD   = w_ldr_stall | w_vec_stall;
    assign StallE   = w_vec_stall;
    assign FlushD   = w_pc_pending | PCSrcW | BranchTakenE;
    // E is held rather than bubbled while a vector op occupies it.
    assign FlushE   = (w_ldr_stall | BranchTakenE) & ~w_vec_stall;
    assign VecBusy  = (r_state == S_BUSY);
    assign VecDoneE = w_vec_done;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with hand-computed expectations
// (VEC_LATENCY=4: three stall cycles, done pulse on the fourth cycle).
module tb_hazard_unit;

    logic       clk;
    logic       rst;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, MemtoRegE;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic       BranchTakenE, VecOpE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE;
    logic       VecBusy, VecDoneE;

    int n_checks;
    int n_fail;
    int n_stall;

    hazard_unit #(.REG_ADDR_W(4), .VEC_LATENCY(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .PCSrcD       (PCSrcD),
        .PCSrcE       (PCSrcE),
        .PCSrcM       (PCSrcM),
        .PCSrcW       (PCSrcW),
        .BranchTakenE (BranchTakenE),
        .VecOpE       (VecOpE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .VecBusy      (VecBusy),
        .VecDoneE     (VecDoneE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // {StallF,StallD,StallE,FlushD,FlushE,VecBusy,VecDoneE}
    function automatic logic [31:0] ctl();
        return {25'd0, StallF, StallD, StallE, FlushD, FlushE, VecBusy, VecDoneE};
    endfunction

    task automatic clear_inputs();
        RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0;
        WA3E = 0; WA3M = 0; WA3W = 0;
        RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
        PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
        BranchTakenE = 0; VecOpE = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        rst = 1'b1;
        #2;
        check("reset_fwd", {28'd0, ForwardAE, ForwardBE}, 32'h0);
        check("reset_ctl", ctl(), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_ctl", ctl(), 32'h0);

        // Forwarding: M beats W
        RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3;
        RA1E = 3; RA2E = 5; #1;
        check("fwdA_M", ForwardAE, 2);
        check("fwdB_none", ForwardBE, 0);
        RegWriteM = 0; #1;
        check("fwdA_W", ForwardAE, 1);
        RA2E = 3; RegWriteM = 1; WA3M = 7; #1;
        check("fwdB_W", ForwardBE, 1);
        check("fwdA_W_mismatchM", ForwardAE, 1);
        clear_inputs(); #1;

        // Load-use
        MemtoRegE = 1; WA3E = 2; RA2D = 2; RA1D = 9; #1;
        check("ldr_ctl", ctl(), 32'b1100100);
        RA2D = 4; #1;
        check("ldr_none", ctl(), 32'h0);
        RA1D = 4; WA3E = 4; #1;
        check("ldr_ra1", ctl(), 32'b1100100);
        clear_inputs(); #1;

        // Branch / PC writes
        BranchTakenE = 1; #1;
        check("branch", ctl(), 32'b0001100);
        BranchTakenE = 0; PCSrcM = 1; #1;
        check("pcsrcM", ctl(), 32'b1001000);
        PCSrcM = 0; PCSrcW = 1; #1;
        check("pcsrcW", ctl(), 32'b0001000);
        clear_inputs(); #1;

        // Branch coincident with VecOpE: no vector start
        BranchTakenE = 1; VecOpE = 1; #1;
        check("br_vec_ctl", ctl(), 32'b0001100);
        tick();
        clear_inputs(); #1;
        check("br_vec_idle", ctl(), 32'h0);

        // Single vector op pulse
        VecOpE = 1; #1;
        check("vec_c1", ctl(), 32'b1110000);
        tick();
        VecOpE = 0; #1;
        check("vec_c2", ctl(), 32'b1110010);
        tick();
        check("vec_c3", ctl(), 32'b1110010);
        tick();
        check("vec_c4_done", ctl(), 32'b0000011);
        tick();
        check("vec_c5_idle", ctl(), 32'h0);

        // VecOpE held through BUSY is ignored
        VecOpE = 1; #1;
        tick(); tick(); tick();
        check("vec_hold_done", ctl(), 32'b0000011);
        VecOpE = 0;
        tick();
        check("vec_hold_idle", ctl(), 32'h0);

        // Load-use during vector stall: stalls only
        VecOpE = 1; #1;
        tick();
        VecOpE = 0;
        MemtoRegE = 1; WA3E = 2; RA2D = 2; #1;
        check("overlap", ctl(), 32'b1110010);
        clear_inputs();
        tick(); tick(); tick();
        check("overlap_idle", ctl(), 32'h0);

        // Async reset mid-BUSY
        VecOpE = 1; #1;
        tick();
        VecOpE = 0; #1;
        check("pre_rst_busy", VecBusy, 1);
        rst = 1'b1; #1;
        check("rst_async", ctl(), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        VecOpE = 1; #1;
        n_stall = 0;
        for (int i = 0; i < 10; i++) begin
            if (StallE) n_stall++;
            if (VecDoneE) break;
            tick();
            VecOpE = 0; #1;
        end
        check("restart_stalls", n_stall, 3);
        check("restart_done", VecDoneE, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
